// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and multiplier FSM encodings.
package alu_pkg;

    localparam int unsigned ALU_N = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/seq_mul_neg2n.sv
// Combinational conditional two's complement negate; with neg_i tied to the
// sign bit it yields the unsigned magnitude.
module neg2n #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? ('0 - a_i) : a_i;

endmodule

// File: rtl/seq_mul.sv
// Multi-cycle shift-add multiplier (signed/unsigned), N iterations per product,
// start/finished handshake shared with the sequential divider.
module seq_mul
    import alu_pkg::*;
#(
    parameter int unsigned N = ALU_N
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic         signed_op,
    input  logic         start,
    output logic [N-1:0] res,
    output logic [N-1:0] high,
    output logic         busy,
    output logic         finished
);

    localparam int unsigned CW = $clog2(N + 1);

    mul_state_t      state_q, state_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [2*N-1:0]  p_q, p_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic [N-1:0]    res_q, res_d;
    logic [N-1:0]    high_q, high_d;
    logic            busy_q, busy_d;
    logic            fin_q, fin_d;

    logic [N-1:0]    x_mag, y_mag;
    logic [N-1:0]    addend;
    logic [N:0]      sum;
    logic [2*N-1:0]  p_shift;
    logic [2*N-1:0]  prod_fin;

    neg2n #(.W(N)) u_neg_x (
        .a_i   (X),
        .neg_i (signed_op & X[N-1]),
        .y_o   (x_mag)
    );

    neg2n #(.W(N)) u_neg_y (
        .a_i   (Y),
        .neg_i (signed_op & Y[N-1]),
        .y_o   (y_mag)
    );

    // One shift-add step: add into the upper half with carry, then shift
    // {carry,P} right by one (P[0] falls off as the multiplier bit retires).
    assign addend  = mplier_q[0] ? mcand_q : '0;
    assign sum     = {1'b0, p_q[2*N-1:N]} + {1'b0, addend};
    assign p_shift = {sum, p_q[N-1:1]};

    neg2n #(.W(2*N)) u_neg_p (
        .a_i   (p_shift),
        .neg_i (neg_q),
        .y_o   (prod_fin)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        res_d    = res_q;
        high_d   = high_q;
        busy_d   = busy_q;
        fin_d    = fin_q;

        if (start) begin
            state_d  = MUL_RUN;
            mcand_d  = x_mag;
            mplier_d = y_mag;
            p_d      = '0;
            cnt_d    = CW'(N);
            neg_d    = signed_op & (X[N-1] ^ Y[N-1]);
            busy_d   = 1'b1;
            fin_d    = 1'b0;
        end else begin
            case (state_q)
                MUL_RUN: begin
                    p_d      = p_shift;
                    mplier_d = {1'b0, mplier_q[N-1:1]};
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        {high_d, res_d} = prod_fin;
                        busy_d          = 1'b0;
                        fin_d           = 1'b1;
                        state_d         = MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    fin_d   = 1'b0;
                    state_d = MUL_IDLE;
                end
                default: state_d = MUL_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            res_q    <= '0;
            high_q   <= '0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            res_q    <= res_d;
            high_q   <= high_d;
            busy_q   <= busy_d;
            fin_q    <= fin_d;
        end
    end

    assign res      = res_q;
    assign high     = high_q;
    assign busy     = busy_q;
    assign finished = fin_q;

endmodule
